// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: control-bit positions
// (also used by the execute stage), FSM state encoding, timer width and
// small decode helpers for the memory-access control field.
package memory_access_stage_pkg;

  // Bit positions inside writeBackControlIn
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // Bit positions inside memAccessControlIn
  localparam int MEM_READ  = 1;
  localparam int MEM_WRITE = 0;

  // Width of the ACCESS-cycle timeout counter
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } memState_t;

  // Exactly one of memRead/memWrite requests a bus transaction
  function automatic logic isBusAccess(input logic [1:0] mac);
    return mac[MEM_READ] ^ mac[MEM_WRITE];
  endfunction

  // Read and write together is not a legal instruction encoding
  function automatic logic isIllegalAccess(input logic [1:0] mac);
    return mac[MEM_READ] & mac[MEM_WRITE];
  endfunction

endpackage

// File: rtl/memory_access_stage_timer.sv
// Counts ACCESS cycles spent waiting for memAck and flags the cycle in which
// the wait has reached its limit, so the stage can abort the access.
module access_timer
  import memory_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  logic [TIMER_W-1:0] r_count;

  // Restart at each launch, advance once per unacknowledged ACCESS cycle
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_terminal = (r_count == TIMER_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: passes ALU results straight into MEM/WB, or runs a
// single load/store over the req/ack bus while holding the upstream stages.
// Every register updates on the falling clock edge like the other pipeline
// registers.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  writeBackControlIn,
  input  logic [1:0]  memAccessControlIn,
  input  logic [31:0] aluResult,
  input  logic [31:0] writeData,
  input  logic [4:0]  rdIn,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic        memReq,
  output logic        memWe,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  output logic        stall,
  output logic        memWbRegWrite,
  output logic [4:0]  memWbRd,
  output logic [31:0] memWbData,
  output logic        busError
);

  memState_t   r_state;
  logic [1:0]  r_wb;
  logic [4:0]  r_rd;
  logic [31:0] r_memAddr;
  logic [31:0] r_memWdata;
  logic        r_memReq;
  logic        r_memWe;
  logic        r_memWbRegWrite;
  logic [4:0]  r_memWbRd;
  logic [31:0] r_memWbData;
  logic        r_busError;

  logic w_launch;
  logic w_illegal;
  logic w_timeout;
  logic w_timerEnable;

  assign w_launch      = (r_state == IDLE) && isBusAccess(memAccessControlIn);
  assign w_illegal     = (r_state == IDLE) && isIllegalAccess(memAccessControlIn);
  assign w_timerEnable = (r_state == ACCESS) && !memAck && !w_timeout;

  access_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_launch),
    .i_enable  (w_timerEnable),
    .o_terminal(w_timeout)
  );

  // Hold upstream from the launch cycle through the last ACCESS cycle; the
  // reset term lets an abandoned access release the pipeline immediately.
  assign stall = !reset && (w_launch || (r_state == ACCESS));

  // Stage FSM: pass-through, launch, wait for ack or timeout, one DONE cycle
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_wb            <= '0;
      r_rd            <= '0;
      r_memAddr       <= '0;
      r_memWdata      <= '0;
      r_memReq        <= 1'b0;
      r_memWe         <= 1'b0;
      r_memWbRegWrite <= 1'b0;
      r_memWbRd       <= '0;
      r_memWbData     <= '0;
      r_busError      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_illegal) begin
            r_memWbRegWrite <= 1'b0;
            r_busError      <= 1'b1;
          end else if (w_launch) begin
            r_memAddr       <= aluResult;
            r_memWdata      <= writeData;
            r_memWe         <= memAccessControlIn[MEM_WRITE];
            r_wb            <= writeBackControlIn;
            r_rd            <= rdIn;
            r_memReq        <= 1'b1;
            r_memWbRegWrite <= 1'b0;
            r_state         <= ACCESS;
          end else begin
            r_memWbRegWrite <= writeBackControlIn[WB_REG_WRITE];
            r_memWbRd       <= rdIn;
            r_memWbData     <= aluResult;
          end
        end
        ACCESS: begin
          if (memAck) begin
            r_memReq        <= 1'b0;
            r_memWbRegWrite <= r_wb[WB_REG_WRITE];
            r_memWbRd       <= r_rd;
            r_memWbData     <= (r_wb[WB_MEM_TO_REG] && !r_memWe) ? memRdata : r_memAddr;
            r_state         <= DONE;
          end else if (w_timeout) begin
            r_memReq        <= 1'b0;
            r_busError      <= 1'b1;
            r_memWbRegWrite <= 1'b0;
            r_memWbData     <= '0;
            r_state         <= DONE;
          end else begin
            r_memWbRegWrite <= 1'b0;
          end
        end
        DONE: begin
          r_memWbRegWrite <= 1'b0;
          r_state         <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign memAddr       = r_memAddr;
  assign memWdata      = r_memWdata;
  assign memReq        = r_memReq;
  assign memWe         = r_memWe;
  assign memWbRegWrite = r_memWbRegWrite;
  assign memWbRd       = r_memWbRd;
  assign memWbData     = r_memWbData;
  assign busError      = r_busError;

endmodule
